// File: rtl/aes_pkg.sv
// Shared AES types, GF(2^8) helper and FSM encoding for the MixColumns engine.
package aes_pkg;

    localparam logic [7:0] AES_POLY_LOW = 8'h1B;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  column_t;
    typedef logic [127:0] state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } mc_state_e;

    // Multiply by x in GF(2^8) mod x^8+x^4+x^3+x+1.
    function automatic byte_t xtime(input byte_t x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY_LOW : 8'h00);
    endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational MixColumns / InvMixColumns of one 32-bit column (row 0 in the top byte).
// Inverse coefficients are composed from xtime chains; no multipliers or tables.
module mix_column_word
    import aes_pkg::*;
#(
    parameter bit SUPPORT_INV = 1'b1
) (
    input  logic [31:0] col_in,
    input  logic        inv,
    output logic [31:0] col_out
);

    byte_t a  [4];
    byte_t x2 [4];
    byte_t x4 [4];
    byte_t x8 [4];
    byte_t fwd [4];
    byte_t rev [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a[i]  = col_in[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
        end
    end

    always_comb begin
        col_out = '0;
        for (int i = 0; i < 4; i++) begin
            fwd[i] = x2[i] ^ (x2[(i+1)%4] ^ a[(i+1)%4]) ^ a[(i+2)%4] ^ a[(i+3)%4];
            // 0e = 8+4+2, 0b = 8+2+1, 0d = 8+4+1, 09 = 8+1
            rev[i] = (x8[i] ^ x4[i] ^ x2[i])
                   ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])
                   ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])
                   ^ (x8[(i+3)%4] ^ a[(i+3)%4]);
            col_out[31-8*i -: 8] = (SUPPORT_INV && inv) ? rev[i] : fwd[i];
        end
    end

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative 128-bit MixColumns/InvMixColumns, COLS_PER_CYCLE columns per RUN cycle.
// Result appears 4/COLS_PER_CYCLE cycles after accept and is held until out_ready.
module mix_columns_iter
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1,
    parameter bit SUPPORT_INV    = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         decrypt,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
            $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [2:0] STEP3    = 3'(COLS_PER_CYCLE);
    localparam logic [1:0] STEP     = STEP3[1:0];
    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

    mc_state_e fsm_q, fsm_d;
    logic [1:0] col_q, col_d;
    state_t     work_q, work_d;
    logic       mode_q, mode_d;

    column_t cols    [4];
    column_t sel_in  [COLS_PER_CYCLE];
    column_t sel_out [COLS_PER_CYCLE];

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            cols[c] = work_q[127-32*c -: 32];
        end
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            sel_in[k] = cols[col_q + 2'(k)];
        end
    end

    genvar g;
    generate
        for (g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
            mix_column_word #(
                .SUPPORT_INV (SUPPORT_INV)
            ) u_word (
                .col_in  (sel_in[g]),
                .inv     (mode_q),
                .col_out (sel_out[g])
            );
        end
    endgenerate

    always_comb begin
        fsm_d  = fsm_q;
        col_d  = col_q;
        work_d = work_q;
        mode_d = mode_q;
        unique case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    work_d = state_in;
                    mode_d = decrypt & SUPPORT_INV;
                    col_d  = 2'd0;
                    fsm_d  = RUN;
                end
            end
            RUN: begin
                for (int c = 0; c < 4; c++) begin
                    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                        if (col_q + 2'(k) == 2'(c)) begin
                            work_d[127-32*c -: 32] = sel_out[k];
                        end
                    end
                end
                col_d = col_q + STEP;
                if (col_q == LAST_COL) begin
                    fsm_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q  <= IDLE;
            col_q  <= 2'd0;
            work_q <= '0;
            mode_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            col_q  <= col_d;
            work_q <= work_d;
            mode_q <= mode_d;
        end
    end

    // Only a finished state is ever visible on state_out.
    assign in_ready  = (fsm_q == IDLE);
    assign out_valid = (fsm_q == HOLD);
    assign busy      = (fsm_q == RUN) || (fsm_q == HOLD);
    assign state_out = (fsm_q == HOLD) ? work_q : '0;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Directed and round-trip checks of mix_columns_iter across column widths and SUPPORT_INV.
module tb_mix_columns_iter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         decrypt = 1'b0;
    logic [127:0] state_in = '0;
    logic         out_ready = 1'b0;
    logic         iv  [4];
    logic         ir  [4];
    logic         ov  [4];
    logic         bsy [4];
    logic [127:0] so  [4];

    int total = 0;
    int bad   = 0;
    logic [127:0] sb [$];

    always #5 clk = ~clk;

    mix_columns_iter #(.COLS_PER_CYCLE(1), .SUPPORT_INV(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .decrypt(decrypt),
        .state_in(state_in), .out_valid(ov[0]), .out_ready(out_ready), .state_out(so[0]), .busy(bsy[0]));
    mix_columns_iter #(.COLS_PER_CYCLE(2), .SUPPORT_INV(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .decrypt(decrypt),
        .state_in(state_in), .out_valid(ov[1]), .out_ready(out_ready), .state_out(so[1]), .busy(bsy[1]));
    mix_columns_iter #(.COLS_PER_CYCLE(4), .SUPPORT_INV(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .decrypt(decrypt),
        .state_in(state_in), .out_valid(ov[2]), .out_ready(out_ready), .state_out(so[2]), .busy(bsy[2]));
    mix_columns_iter #(.COLS_PER_CYCLE(1), .SUPPORT_INV(1'b0)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .decrypt(decrypt),
        .state_in(state_in), .out_valid(ov[3]), .out_ready(out_ready), .state_out(so[3]), .busy(bsy[3]));

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
        logic [127:0] r = '0;
        logic [7:0] a [4];
        logic [7:0] coef [4];
        logic [7:0] acc;
        if (inv) begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) a[i] = s[127-32*c-8*i -: 8];
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ gmul(a[(i+j)%4], coef[j]);
                r[127-32*c-8*i -: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic txn(input int d, input logic [127:0] din, input logic dec,
                       input logic [127:0] exp, input int exp_lat, input int hold);
        int lat = 0;
        logic [127:0] e;
        sb.push_back(exp);
        @(negedge clk);
        state_in = din;
        decrypt  = dec;
        iv[d]    = 1'b1;
        chk("in_ready_idle", 128'(ir[d]), 128'd1);
        @(posedge clk);
        #1;
        iv[d]    = 1'b0;
        state_in = {$urandom, $urandom, $urandom, $urandom};
        decrypt  = ~dec;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ov[d]) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            chk("out_valid_timeout", 128'd0, 128'd1);
            void'(sb.pop_front());
            return;
        end
        chk("latency", 128'(lat), 128'(exp_lat));
        chk("busy_hold", 128'(bsy[d]), 128'd1);
        chk("in_ready_hold", 128'(ir[d]), 128'd0);
        e = sb.pop_front();
        chk("state_out", so[d], e);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("stall_state_out", so[d], e);
            chk("stall_out_valid", 128'(ov[d]), 128'd1);
            chk("stall_in_ready", 128'(ir[d]), 128'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("in_ready_after", 128'(ir[d]), 128'd1);
        chk("out_valid_after", 128'(ov[d]), 128'd0);
    endtask

    initial begin
        logic [127:0] r, f;
        for (int d = 0; d < 4; d++) iv[d] = 1'b0;

        #2;
        for (int d = 0; d < 4; d++) begin
            chk("rst_in_ready", 128'(ir[d]), 128'd1);
            chk("rst_out_valid", 128'(ov[d]), 128'd0);
            chk("rst_busy", 128'(bsy[d]), 128'd0);
            chk("rst_state_out", so[d], 128'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Single-column vectors replicated across all four columns.
        txn(0, {4{32'hdb135345}}, 1'b0, {4{32'h8e4da1bc}}, 4, 0);
        txn(0, {4{32'hf20a225c}}, 1'b0, {4{32'h9fdc589d}}, 4, 0);

        // Full-state vector at each column width.
        txn(0, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0,
               128'h046681e5_e0cb199a_48f8d37a_2806264c, 4, 0);
        txn(1, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0,
               128'h046681e5_e0cb199a_48f8d37a_2806264c, 2, 0);
        txn(2, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0,
               128'h046681e5_e0cb199a_48f8d37a_2806264c, 1, 0);

        // Inverse direction.
        txn(0, {4{32'h8e4da1bc}}, 1'b1, {4{32'hdb135345}}, 4, 0);
        txn(0, {16{8'hc6}}, 1'b1, {16{8'hc6}}, 4, 0);
        txn(1, {4{32'h8e4da1bc}}, 1'b1, {4{32'hdb135345}}, 2, 0);
        txn(2, {4{32'h8e4da1bc}}, 1'b1, {4{32'hdb135345}}, 1, 0);

        // Without inverse logic, decrypt is ignored.
        txn(3, {4{32'h2d26314c}}, 1'b1, {4{32'h4d7ebdf8}}, 4, 0);

        // Backpressure: result held for 10 cycles.
        txn(0, 128'h00112233_44556677_8899aabb_ccddeeff, 1'b0,
               model(128'h00112233_44556677_8899aabb_ccddeeff, 1'b0), 4, 10);

        // Reset in the second RUN cycle.
        @(negedge clk);
        state_in = {4{32'hdb135345}};
        decrypt  = 1'b0;
        iv[0]    = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_out_valid", 128'(ov[0]), 128'd0);
        chk("midrun_busy", 128'(bsy[0]), 128'd0);
        chk("midrun_state_out", so[0], 128'd0);
        chk("midrun_in_ready", 128'(ir[0]), 128'd1);
        @(negedge clk);
        rst_n = 1'b1;
        txn(0, {4{32'hf20a225c}}, 1'b0, {4{32'h9fdc589d}}, 4, 0);

        // Random round trips.
        for (int n = 0; n < 1000; n++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            f = model(r, 1'b0);
            txn(0, r, 1'b0, f, 4, 0);
            txn(0, f, 1'b1, r, 4, 0);
        end
        for (int n = 0; n < 20; n++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            txn(1, r, n[0], model(r, n[0]), 2, 0);
            txn(2, r, n[0], model(r, n[0]), 1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
